tage_port_sched: RTL
====================

// Module: tage_port_sched
// PURPOSE
//  Scheduler for the TAGE predictor's single table port (idx/update_en/br_result/correct).
//  Arbitrates each cycle between a front-end lookup and a queued branch-resolution update.
//  Buffers resolutions in a small FIFO and bounds update starvation. Sits between
//  fetch/commit and tage_predictor.
// PARAMETERS
//  IDX_W       32  branch index width (matches predictor idx)
//  DEPTH       4   resolution FIFO entries (power of 2, >=2)
//  STARVE_MAX  8   consecutive lookup grants with FIFO non-empty before an update is forced
// PORTS
//  clk_i           in   1                   clock, all state on rising edge
//  rst_i           in   1                   synchronous, active-low reset
//  lkp_valid_i     in   1                   lookup request
//  lkp_idx_i       in   IDX_W               lookup index
//  lkp_ready_o     out  1                   lookup granted this cycle
//  res_valid_i     in   1                   resolved branch push
//  res_idx_i       in   IDX_W               resolved branch index
//  res_taken_i     in   1                   actual outcome
//  res_correct_i   in   1                   prediction was correct
//  res_ready_o     out  1                   FIFO accepts push this cycle
//  tp_idx_o        out  IDX_W               predictor index
//  tp_update_en_o  out  1                   predictor update strobe
//  tp_br_result_o  out  1                   predictor outcome
//  tp_correct_o    out  1                   predictor correct flag
//  tp_prediction_i in   1                   predictor output, valid 1 cycle after lookup grant
//  pred_valid_o    out  1                   prediction response valid
//  pred_taken_o    out  1                   prediction response
//  occ_o           out  $clog2(DEPTH+1)     FIFO occupancy
// BEHAVIOUR
//  - Reset (rst_i==0 at posedge): FIFO emptied (in-flight entries dropped), occ_o=0, state=NORMAL,
//    starve_cnt=0, pred_valid_o=0. While rst_i==0: lkp_ready_o, res_ready_o, tp_update_en_o all 0.
//  - Grant per cycle, exactly one of NONE/LKP/UPD:
//    NORMAL: lkp_valid_i & FIFO not full -> LKP; else FIFO non-empty -> UPD; else NONE.
//    FORCE: FIFO non-empty -> UPD (lkp_ready_o=0); else NONE.
//    Full FIFO always -> UPD; a lookup is never granted while occ_o==DEPTH.
//  - FSM NORMAL->FORCE when an LKP grant occurs with FIFO non-empty and starve_cnt==STARVE_MAX-1.
//    FORCE->NORMAL after exactly one cycle.
//  - starve_cnt: +1 on LKP grant with FIFO non-empty; cleared on any UPD grant or when FIFO is empty;
//    saturates at STARVE_MAX-1.
//  - LKP grant: tp_idx_o=lkp_idx_i, tp_update_en_o=0; pred_valid_o=1 next cycle,
//    pred_taken_o=tp_prediction_i (combinational pass). pred_taken_o=0 when pred_valid_o=0.
//  - UPD grant: tp_idx_o/br_result_o/correct_o = FIFO head; tp_update_en_o=1; head pops same cycle.
//  - NONE: tp_idx_o=0, tp_br_result_o=0, tp_correct_o=0, tp_update_en_o=0.
//  - res_ready_o = !full | (UPD grant this cycle). Push on res_valid_i&res_ready_o.
//    Simultaneous push+pop leaves occ_o unchanged, including at full.
//    Pop when empty cannot occur. Push to an empty FIFO is not poppable until the next cycle
//    (no bypass).
//  - Pointers are $clog2(DEPTH) bits and wrap naturally; occ_o tracks full vs empty.
// STRUCTURE
//  - tage_pkg: grant_e {GNT_NONE,GNT_LKP,GNT_UPD}; sched_state_e {ST_NORMAL,ST_FORCE};
//    upd_entry_t {idx, taken, correct}.
//  - Sub-module tage_upd_fifo: sync FIFO of upd_entry_t with push/pop/full/empty/occ.
//    The scheduler keeps the FSM, starvation counter, grant mux and response register.
// TESTING
//  1. Reset mid-run with occ_o=3 -> next cycle occ_o=0, pred_valid_o=0,
//     no tp_update_en_o until a new push.
//  2. Lookup only, idx=0x40, tp_prediction_i=1 -> lkp_ready_o=1, tp_idx_o=0x40;
//     next cycle pred_valid_o=1, pred_taken_o=1.
//  3. One push (idx=0x10, taken=1, correct=0), lkp_valid_i held high -> 8 lookup grants,
//     then 1 cycle lkp_ready_o=0 with tp_update_en_o=1, tp_idx_o=0x10, tp_br_result_o=1,
//     tp_correct_o=0; then lookups resume.
//  4. Push 4 back-to-back with lkp_valid_i high -> occ_o=4, lkp_ready_o=0, UPD granted;
//     a push in that cycle is accepted and occ_o stays 4.
//  5. No lookups, push then idle -> update issues the cycle after the push; FIFO order preserved
//     across pointer wrap (push 6 entries, pops in push order).
//  6. res_valid_i with occ_o=4 and no pop -> res_ready_o=0, entry not stored, occ_o unchanged.

Source files
------------

// File: rtl/tage_pkg.sv
// Shared types for the TAGE table-port scheduler and its resolution FIFO.
package tage_pkg;

    localparam int TAGE_IDX_W = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LKP  = 2'd1,
        GNT_UPD  = 2'd2
    } grant_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [TAGE_IDX_W-1:0] idx;
        logic                  taken;
        logic                  correct;
    } upd_entry_t;

endpackage

// File: rtl/tage_upd_fifo.sv
// Synchronous FIFO of branch resolutions; head is read combinationally, no write-to-read bypass.
module tage_upd_fifo
    import tage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  upd_entry_t                 push_data_i,
    input  logic                       pop_i,
    output upd_entry_t                 head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    upd_entry_t      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i)      occ_d = occ_q + 1'b1;
        else if (pop_i && !push_i) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (occ_q == OW'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/tage_port_sched.sv
// Arbitrates the single TAGE table port between front-end lookups and queued resolution updates.
//  state     | meaning
//  S_NORMAL  | lookups win unless the FIFO is full
//  S_FORCE   | one cycle where a pending update is issued ahead of lookups
module tage_port_sched
    import tage_pkg::*;
#(
    parameter int IDX_W      = TAGE_IDX_W,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       lkp_valid_i,
    input  logic [IDX_W-1:0]           lkp_idx_i,
    output logic                       lkp_ready_o,
    input  logic                       res_valid_i,
    input  logic [IDX_W-1:0]           res_idx_i,
    input  logic                       res_taken_i,
    input  logic                       res_correct_i,
    output logic                       res_ready_o,
    output logic [IDX_W-1:0]           tp_idx_o,
    output logic                       tp_update_en_o,
    output logic                       tp_br_result_o,
    output logic                       tp_correct_o,
    input  logic                       tp_prediction_i,
    output logic                       pred_valid_o,
    output logic                       pred_taken_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o
);

    localparam logic [0:0] S_NORMAL = 1'(ST_NORMAL);
    localparam logic [0:0] S_FORCE  = 1'(ST_FORCE);
    localparam int         SW       = $clog2(STARVE_MAX+1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX-1);

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          pred_valid_q, pred_valid_d;
    grant_e        grant;
    logic          full, empty, push, pop;
    upd_entry_t    head, push_data;

    always_comb begin
        grant = GNT_NONE;
        if (!rst_i)                 grant = GNT_NONE;
        else if (full)              grant = GNT_UPD;
        else if (state_q == S_FORCE) grant = empty ? GNT_NONE : GNT_UPD;
        else if (lkp_valid_i)       grant = GNT_LKP;
        else if (!empty)            grant = GNT_UPD;
    end

    assign pop         = (grant == GNT_UPD);
    assign lkp_ready_o = (grant == GNT_LKP);
    assign res_ready_o = rst_i && (!full || pop);
    assign push        = res_valid_i && res_ready_o;

    assign push_data.idx     = res_idx_i;
    assign push_data.taken   = res_taken_i;
    assign push_data.correct = res_correct_i;

    tage_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .occ_o       (occ_o)
    );

    always_comb begin
        tp_idx_o       = '0;
        tp_update_en_o = 1'b0;
        tp_br_result_o = 1'b0;
        tp_correct_o   = 1'b0;
        if (grant == GNT_LKP) begin
            tp_idx_o = lkp_idx_i;
        end else if (grant == GNT_UPD) begin
            tp_idx_o       = head.idx;
            tp_update_en_o = 1'b1;
            tp_br_result_o = head.taken;
            tp_correct_o   = head.correct;
        end
    end

    // Starvation only accrues while an update is waiting behind a lookup.
    always_comb begin
        starve_d     = starve_q;
        state_d      = S_NORMAL;
        pred_valid_d = (grant == GNT_LKP);
        if (pop || empty) begin
            starve_d = '0;
        end else if (grant == GNT_LKP && starve_q != STARVE_LAST) begin
            starve_d = starve_q + 1'b1;
        end
        if (state_q == S_NORMAL && grant == GNT_LKP && !empty && starve_q == STARVE_LAST)
            state_d = S_FORCE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_NORMAL;
            starve_q     <= '0;
            pred_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            pred_valid_q <= pred_valid_d;
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = pred_valid_q && tp_prediction_i;

endmodule
